// File: rtl/addsub_slice_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_slice_sequencer_pkg
// Brief    : Shared ALU definitions: sequencer state encoding and slice width.
// Revision : 1.0
// ============================================================================
package addsub_slice_sequencer_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/addsub_slice_sequencer_csa8.sv
`default_nettype none
// ============================================================================
// Module   : addsub_slice_sequencer_csa8
// Brief    : 8-bit carry-select adder slice; also exports the carry into bit 7.
// Revision : 1.0
// ============================================================================
module addsub_slice_sequencer_csa8
  import addsub_slice_sequencer_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               second_out
);

  logic [4:0] w_lo;
  logic [3:0] w_hi0;
  logic [3:0] w_hi1;
  logic       w_s7_0;
  logic       w_s7_1;
  logic       w_co_0;
  logic       w_co_1;

  assign w_lo = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};

  // Upper nibble precomputed for both low-nibble carries; bit 3 of w_hi* is
  // the carry into bit 7, needed separately for signed overflow.
  assign w_hi0 = {1'b0, a[6:4]} + {1'b0, b[6:4]};
  assign w_hi1 = {1'b0, a[6:4]} + {1'b0, b[6:4]} + 4'd1;

  assign w_s7_0 = a[7] ^ b[7] ^ w_hi0[3];
  assign w_s7_1 = a[7] ^ b[7] ^ w_hi1[3];
  assign w_co_0 = (a[7] & b[7]) | (a[7] & w_hi0[3]) | (b[7] & w_hi0[3]);
  assign w_co_1 = (a[7] & b[7]) | (a[7] & w_hi1[3]) | (b[7] & w_hi1[3]);

  assign sum        = w_lo[4] ? {w_s7_1, w_hi1[2:0], w_lo[3:0]}
                              : {w_s7_0, w_hi0[2:0], w_lo[3:0]};
  assign cout       = w_lo[4] ? w_co_1   : w_co_0;
  assign second_out = w_lo[4] ? w_hi1[3] : w_hi0[3];

endmodule
`default_nettype wire

// File: rtl/addsub_slice_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : addsub_slice_sequencer
// Brief    : Multi-cycle add/subtract, one 8-bit slice per cycle, LS slice first.
// Revision : 1.0
// ============================================================================
module addsub_slice_sequencer
  import addsub_slice_sequencer_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NSLICE = WIDTH / SLICE_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NSLICE - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry_out;
  logic               r_overflow;
  logic [SLICE_W-1:0] w_sum;
  logic               w_cout;
  logic               w_c7;
  logic               w_last;

  assign w_last = (r_cnt == C_LAST);

  addsub_slice_sequencer_csa8 u_slice (
    .a          (r_a[SLICE_W*r_cnt +: SLICE_W]),
    .b          (r_b[SLICE_W*r_cnt +: SLICE_W]),
    .cin        (r_carry),
    .sum        (w_sum),
    .cout       (w_cout),
    .second_out (w_c7)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Subtraction is folded in at acceptance: B is inverted and the carry
  // register seeded with 1, so the slice only ever adds.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= op_b ^ {WIDTH{op_sub}};
            r_carry <= op_sub;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          r_result[SLICE_W*r_cnt +: SLICE_W] <= w_sum;
          r_carry <= w_cout;
          if (w_last) begin
            r_cnt       <= '0;
            r_carry_out <= w_cout;
            r_overflow  <= w_cout ^ w_c7;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  // Gated so that it reads 0 out of reset and outside a valid result.
  assign zero      = out_valid && (r_result == '0);

endmodule
`default_nettype wire
